// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target endpoint: FSM state encoding,
// default bus address and the address-compare helper.
package i2c_target_pkg;

    localparam logic [6:0] DEFAULT_ADDR = 7'h52;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR     = 4'd1,
        S_ADDR_ACK = 4'd2,
        S_RX       = 4'd3,
        S_RX_ACK   = 4'd4,
        S_TX       = 4'd5,
        S_TX_ACK   = 4'd6,
        S_IGNORE   = 4'd7
    } state_t;

    // Address byte carries the 7-bit address in [7:1] and R/W in [0].
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] addr);
        return addr_byte[7:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Bus pins plus the byte-level handshake between the I2C target and local logic.
interface i2c_target_if;

    logic       scl_in;
    logic       sda_in;
    logic       sda_out;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       tx_load;
    logic [7:0] tx_data;
    logic       busy;
    logic       start_det;
    logic       stop_det;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_out, rx_data, rx_valid, rx_first, tx_load, busy, start_det, stop_det
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_out, rx_data, rx_valid, rx_first, tx_load, busy, start_det, stop_det
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into clk and derives SCL edges and START/STOP conditions.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_s;

    // Idle bus level is high, so everything resets to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev;
    assign scl_fall = ~scl_s & scl_prev;
    assign start    = scl_s & sda_prev & ~sda_s;
    assign stop     = scl_s & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: address match, byte receive with ACK, byte transmit with
// master ACK/NACK, open-drain SDA drive changed only after SCL falls.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] ADDR        = DEFAULT_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    i2c_target_if.slave     bus
);

    logic sda_s, scl_rise, scl_fall, start, stop;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (bus.scl_in),
        .sda_in   (bus.sda_in),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    state_t     state_q, state_d;
    logic [2:0] bit_ctr_q, bit_ctr_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    // phase: ACK already driven (ADDR_ACK/RX_ACK) or master ACKed (TX_ACK).
    logic       phase_q, phase_d;
    logic       first_arm_q, first_arm_d;
    logic       busy_q, busy_d;
    logic       sda_out_q, sda_out_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q, stop_det_d;
    logic       tx_load;

    // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        bit_ctr_d   = bit_ctr_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        phase_d     = phase_q;
        first_arm_d = first_arm_q;
        busy_d      = busy_q;
        sda_out_d   = sda_out_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_first_d  = 1'b0;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;
        tx_load     = 1'b0;

        if (stop) begin
            state_d    = S_IDLE;
            sda_out_d  = 1'b1;
            busy_d     = 1'b0;
            stop_det_d = 1'b1;
        end else if (start) begin
            state_d     = S_ADDR;
            bit_ctr_d   = 3'd0;
            sda_out_d   = 1'b1;
            busy_d      = 1'b0;
            start_det_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_ADDR: if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_ctr_d = bit_ctr_q + 3'd1;
                    if (bit_ctr_q == 3'd7) begin
                        if (addr_match(shift_d, ADDR)) begin
                            state_d = S_ADDR_ACK;
                            busy_d  = 1'b1;
                            rw_d    = sda_s;
                            phase_d = 1'b0;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_out_d = 1'b0;
                        phase_d   = 1'b1;
                    end else if (!rw_q) begin
                        state_d     = S_RX;
                        sda_out_d   = 1'b1;
                        bit_ctr_d   = 3'd0;
                        first_arm_d = 1'b1;
                    end else begin
                        // tx_load is combinational so tx_data is captured on this same edge.
                        state_d   = S_TX;
                        tx_load   = 1'b1;
                        shift_d   = bus.tx_data;
                        sda_out_d = bus.tx_data[7];
                        bit_ctr_d = 3'd0;
                    end
                end
                S_RX: if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_ctr_d = bit_ctr_q + 3'd1;
                    if (bit_ctr_q == 3'd7) begin
                        state_d     = S_RX_ACK;
                        rx_data_d   = shift_d;
                        rx_valid_d  = 1'b1;
                        rx_first_d  = first_arm_q;
                        first_arm_d = 1'b0;
                        phase_d     = 1'b0;
                    end
                end
                S_RX_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_out_d = 1'b0;
                        phase_d   = 1'b1;
                    end else begin
                        state_d   = S_RX;
                        sda_out_d = 1'b1;
                    end
                end
                S_TX: if (scl_fall) begin
                    bit_ctr_d = bit_ctr_q + 3'd1;
                    if (bit_ctr_q == 3'd7) begin
                        state_d   = S_TX_ACK;
                        sda_out_d = 1'b1;
                        phase_d   = 1'b0;
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_out_d = shift_q[6];
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d   = S_IGNORE;
                            sda_out_d = 1'b1;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        state_d   = S_TX;
                        tx_load   = 1'b1;
                        shift_d   = bus.tx_data;
                        sda_out_d = bus.tx_data[7];
                        bit_ctr_d = 3'd0;
                    end
                end
                S_IGNORE: sda_out_d = 1'b1;
                default: begin
                    state_d   = S_IDLE;
                    sda_out_d = 1'b1;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_ctr_q   <= 3'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            phase_q     <= 1'b0;
            first_arm_q <= 1'b0;
            busy_q      <= 1'b0;
            sda_out_q   <= 1'b1;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_first_q  <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_ctr_q   <= bit_ctr_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            phase_q     <= phase_d;
            first_arm_q <= first_arm_d;
            busy_q      <= busy_d;
            sda_out_q   <= sda_out_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_first_q  <= rx_first_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
        end
    end

    assign bus.sda_out   = sda_out_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_first  = rx_first_q;
    assign bus.tx_load   = tx_load;
    assign bus.busy      = busy_q;
    assign bus.start_det = start_det_q;
    assign bus.stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C master at a 500-clk SCL period
// on a wired-AND SDA line, with monitors counting handshake pulses.
module tb_i2c_target;
    import i2c_target_pkg::*;

    localparam int Q = 125;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] tx_byte = 8'hFF;

    int checks = 0;
    int failures = 0;

    i2c_target_if bus ();

    assign bus.scl_in  = m_scl;
    assign bus.sda_in  = m_sda & bus.sda_out;
    assign bus.tx_data = tx_byte;

    i2c_target #(.ADDR(7'h52), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Monitors sample on the falling clk edge, away from the active edge.
    logic [8:0] rx_q[$];
    int tx_cnt = 0, start_cnt = 0, stop_cnt = 0, low_cnt = 0;

    always @(negedge clk) begin
        if (bus.rx_valid) rx_q.push_back({bus.rx_first, bus.rx_data});
        if (bus.tx_load) tx_cnt++;
        if (bus.start_det) start_cnt++;
        if (bus.stop_det) stop_cnt++;
        if (bus.sda_out === 1'b0) low_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        m_sda = b;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        r = bus.sda_in;
        wait_clk(Q);
        m_scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) xfer_bit(d[i], r);
        xfer_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, r);
            d[i] = r;
        end
        xfer_bit(ack, r);
    endtask

    task automatic bus_start();
        m_sda = 1'b1;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        m_sda = 1'b0;
        wait_clk(Q);
        m_scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        m_sda = 1'b1;
        wait_clk(Q);
    endtask

    initial begin
        logic       ack;
        logic       r;
        logic [7:0] rd;
        logic [7:0] wr_bytes[3];
        logic [7:0] addr_bits;
        int rb, tb0, sb, pb, lb;

        wr_bytes[0] = 8'h00;
        wr_bytes[1] = 8'hA5;
        wr_bytes[2] = 8'h5A;

        // Reset state
        wait_clk(5);
        check("rst_sda_out", bus.sda_out, 1);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_tx_load", bus.tx_load, 0);
        check("rst_start_det", bus.start_det, 0);
        check("rst_stop_det", bus.stop_det, 0);
        check("rst_state", dut.state_q, S_IDLE);
        rst = 1'b0;
        wait_clk(10);

        // Single-byte write
        rb = rx_q.size(); sb = stop_cnt; pb = start_cnt;
        bus_start();
        write_byte(8'hA4, ack);
        check("t1_addr_ack", ack, 0);
        check("t1_busy", bus.busy, 1);
        write_byte(8'h3C, ack);
        check("t1_data_ack", ack, 0);
        bus_stop();
        wait_clk(10);
        check("t1_rx_count", rx_q.size() - rb, 1);
        if (rx_q.size() > rb) begin
            check("t1_rx_data", rx_q[rb][7:0], 8'h3C);
            check("t1_rx_first", rx_q[rb][8], 1);
        end
        check("t1_start_cnt", start_cnt - pb, 1);
        check("t1_stop_cnt", stop_cnt - sb, 1);
        check("t1_busy_after", bus.busy, 0);

        // Three-byte write
        rb = rx_q.size();
        bus_start();
        write_byte(8'hA4, ack);
        check("t2_addr_ack", ack, 0);
        for (int i = 0; i < 3; i++) begin
            write_byte(wr_bytes[i], ack);
            check("t2_data_ack", ack, 0);
        end
        bus_stop();
        wait_clk(10);
        check("t2_rx_count", rx_q.size() - rb, 3);
        if (rx_q.size() >= rb + 3) begin
            for (int i = 0; i < 3; i++) begin
                check("t2_rx_data", rx_q[rb+i][7:0], wr_bytes[i]);
                check("t2_rx_first", rx_q[rb+i][8], (i == 0) ? 1 : 0);
            end
        end

        // Two-byte read, ACK then NACK
        tb0 = tx_cnt;
        tx_byte = 8'hC3;
        bus_start();
        write_byte(8'hA5, ack);
        check("t3_addr_ack", ack, 0);
        tx_byte = 8'h81;
        read_byte(1'b0, rd);
        check("t3_rd0", rd, 8'hC3);
        tx_byte = 8'hFF;
        read_byte(1'b1, rd);
        check("t3_rd1", rd, 8'h81);
        wait_clk(10);
        check("t3_tx_load_cnt", tx_cnt - tb0, 2);
        check("t3_sda_released", bus.sda_out, 1);
        check("t3_state", dut.state_q, S_IGNORE);
        bus_stop();
        wait_clk(10);

        // Foreign address is ignored
        rb = rx_q.size(); tb0 = tx_cnt; lb = low_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check("t4_addr_nack", ack, 1);
        wait_clk(10);
        check("t4_state", dut.state_q, S_IGNORE);
        check("t4_busy", bus.busy, 0);
        bus_stop();
        wait_clk(10);
        check("t4_sda_low_cycles", low_cnt - lb, 0);
        check("t4_rx_count", rx_q.size() - rb, 0);
        check("t4_tx_count", tx_cnt - tb0, 0);

        // Write pointer, repeated START, read
        rb = rx_q.size(); tb0 = tx_cnt; pb = start_cnt;
        bus_start();
        write_byte(8'hA4, ack);
        check("t5_waddr_ack", ack, 0);
        write_byte(8'h10, ack);
        check("t5_ptr_ack", ack, 0);
        check("t5_tx_before", tx_cnt - tb0, 0);
        tx_byte = 8'h77;
        bus_start();
        check("t5_busy_after_sr", bus.busy, 0);
        write_byte(8'hA5, ack);
        check("t5_raddr_ack", ack, 0);
        check("t5_tx_after", tx_cnt - tb0, 1);
        read_byte(1'b1, rd);
        check("t5_rd", rd, 8'h77);
        bus_stop();
        wait_clk(10);
        check("t5_start_cnt", start_cnt - pb, 2);
        check("t5_rx_count", rx_q.size() - rb, 1);
        if (rx_q.size() > rb) begin
            check("t5_rx_data", rx_q[rb][7:0], 8'h10);
            check("t5_rx_first", rx_q[rb][8], 1);
        end

        // Asynchronous reset while the address ACK is being driven
        bus_start();
        addr_bits = 8'hA4;
        for (int i = 7; i >= 0; i--) xfer_bit(addr_bits[i], r);
        m_sda = 1'b1;
        check("t6_ack_driven", bus.sda_out, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("t6_async_release", bus.sda_out, 1);
        check("t6_async_state", dut.state_q, S_IDLE);
        wait_clk(5);
        rst = 1'b0;
        wait_clk(10);
        rb = rx_q.size();
        bus_start();
        write_byte(8'hA4, ack);
        check("t6_addr_ack", ack, 0);
        write_byte(8'h11, ack);
        check("t6_data_ack", ack, 0);
        bus_stop();
        wait_clk(10);
        check("t6_rx_count", rx_q.size() - rb, 1);
        if (rx_q.size() > rb) check("t6_rx_data", rx_q[rb][7:0], 8'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
